pcs_tx_sched: RTL and testbench
===============================

// Module: pcs_tx_sched
// PURPOSE
// Slot scheduler for the PCS transmit path (encoder, scrambler, alignment-marker insert, gearbox).
// - Tracks the gearbox sequence, so the MAC is stalled on the cycle where the gearbox is full.
// - In 40G mode, picks the block slots where the alignment marker replaces data, holding the scrambler on those slots.
// - Produces ready_o towards the MAC, plus the per-slot control strobes for the PCS datapath.
// PARAMETERS
// IS_10G     0                          1: 10GBASE-R (no markers); 0: 40GBASE-R (markers on all lanes at once)
// DATA_W     64                         block payload width, in bits
// HEAD_W     2                          sync header width, in bits
// AM_PERIOD  16384                      blocks per lane from one marker to the next, marker included (>=4)
// SEQ_W      $clog2(DATA_W/HEAD_W+1)    width of the gearbox sequence counter
// AM_W       $clog2(AM_PERIOD)          width of the marker counter
// PORTS
// clk           in   1      clock
// nreset        in   1      reset: synchronous, active-low
// en_i          in   1      transmit enable from management; 0 = send idles only
// ready_o       out  1      MAC data is consumed this cycle
// marker_v_o    out  1      this slot carries the alignment marker (always 0 when IS_10G)
// scram_v_o     out  1      scrambler advances this cycle
// gb_pause_o    out  1      gearbox full: no block is consumed this cycle
// gb_seq_o      out  SEQ_W  gearbox sequence, 0..DATA_W/HEAD_W
// idle_force_o  out  1      encoder must emit idle control blocks; MAC data is ignored
// am_cnt_o      out  AM_W   current marker counter value (debug/verification)
// BEHAVIOUR
// - Registers: state (IDLE, RUN), gb_seq, am_cnt.
// - All outputs are decoded combinationally from these registers only. There is no combinational path from en_i.
// - Reset (nreset=0 at a clk edge):
//   - state=IDLE, gb_seq=0, am_cnt=0.
//   - Resulting outputs: ready_o=0, marker_v_o=0, gb_pause_o=0, scram_v_o=1, idle_force_o=1.
//   - Reset mid-operation aborts immediately; any pending marker is dropped.
// - Gearbox sequence:
//   - Free-running in both states.
//   - gb_seq_next = (gb_seq==DATA_W/HEAD_W) ? 0 : gb_seq+1; no overflow beyond DATA_W/HEAD_W.
//   - gb_pause_o = (gb_seq==DATA_W/HEAD_W). Default: asserted 1 cycle in every 33.
// - A block slot is a cycle with gb_pause_o=0.
// - FSM:
//   - IDLE: idle_force_o=1, ready_o=0, marker_v_o=0.
//     - en_i=1 sampled -> RUN next cycle.
//     - On that transition, am_cnt loads AM_PERIOD-1 in 40G, so the first block slot in RUN is a marker; it loads 0 in 10G.
//   - RUN: idle_force_o=0.
//     - en_i=0 sampled -> IDLE next cycle, am_cnt<=0.
//     - The current slot still completes as decoded.
// - Marker, 40G, RUN only:
//   - marker_v_o = (am_cnt==AM_PERIOD-1) & ~gb_pause_o.
//   - am_cnt advances only on block slots: it wraps to 0 after the marker slot, otherwise +1.
//   - am_cnt holds on pause cycles.
//   - If the marker is due on a pause cycle, the marker is deferred to the next block slot. Pause has priority.
//   - In 10G: am_cnt is held at 0 and marker_v_o=0.
// - ready_o = RUN & ~gb_pause_o & ~marker_v_o.
//   - The MAC must hold its data when ready_o=0.
//   - Latency from ready_o=1 to the encoder input is 0 cycles; data is consumed in the same cycle.
// - scram_v_o = ~marker_v_o & ~gb_pause_o.
//   - The scrambler state is frozen on marker and pause slots.
//   - In IDLE the scrambler advances on idle blocks.
// - Data blocks per marker period in RUN = AM_PERIOD-1. Pause cycles are not counted.
// TESTING (bench parameters: AM_PERIOD=8, DATA_W=64, HEAD_W=2)
// 1. Hold nreset=0 for 3 cycles, then release with en_i=0 for 40 cycles.
//    -> ready_o=0, marker_v_o=0, idle_force_o=1 throughout.
//    -> gb_seq counts 0..32; gb_pause_o=1 exactly when gb_seq=32.
// 2. Raise en_i at gb_seq=5.
//    -> RUN from the next cycle; at gb_seq=6, marker_v_o=1 and ready_o=0.
//    -> The next 7 block slots have ready_o=1.
//    -> The following block slot has marker_v_o=1.
// 3. Align so am_cnt=7 when gb_seq=32.
//    -> That cycle: gb_pause_o=1, marker_v_o=0, ready_o=0, am_cnt holds at 7.
//    -> At gb_seq=0: marker_v_o=1; then am_cnt=0.
// 4. Keep en_i=1 for 330 cycles.
//    -> Count of ready_o=1 equals 7 times the count of marker_v_o=1, within 1 period of slack.
//    -> scram_v_o=0 exactly on marker and pause cycles.
// 5. Drop en_i in RUN at am_cnt=3; pulse nreset=0 for 1 cycle during a later RUN.
//    -> IDLE next cycle with am_cnt=0.
//    -> After the reset, all outputs are back at their reset values and gb_seq=0.
// 6. IS_10G=1, en_i=1 for 100 cycles.
//    -> marker_v_o never set; ready_o=~gb_pause_o; am_cnt_o=0.

Source files
------------

// File: rtl/pcs_tx_sched.sv
// Slot scheduler for the PCS transmit path: gearbox pause tracking, alignment-marker
// slot selection (40G) and the ready/scrambler/idle strobes derived from them.
module pcs_tx_sched #(
   parameter int IS_10G    = 0,
   parameter int DATA_W    = 64,
   parameter int HEAD_W    = 2,
   parameter int AM_PERIOD = 16384,
   parameter int SEQ_W     = $clog2(DATA_W/HEAD_W+1),
   parameter int AM_W      = $clog2(AM_PERIOD)
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             en_i,
   output logic             ready_o,
   output logic             marker_v_o,
   output logic             scram_v_o,
   output logic             gb_pause_o,
   output logic [SEQ_W-1:0] gb_seq_o,
   output logic             idle_force_o,
   output logic [AM_W-1:0]  am_cnt_o
);

   localparam bit              IS10     = (IS_10G != 0);
   localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(DATA_W/HEAD_W);
   localparam logic [AM_W-1:0]  AM_LAST  = AM_W'(AM_PERIOD-1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state;
   logic [SEQ_W-1:0]  gb_seq;
   logic [AM_W-1:0]   am_cnt;

   logic              pause;
   logic              marker;
   logic              running;

   // Outputs decode from registers only, so en_i never reaches an output combinationally.
   assign running      = (state == RUN);
   assign pause        = (gb_seq == SEQ_LAST);
   assign marker       = !IS10 && running && (am_cnt == AM_LAST) && !pause;

   assign gb_pause_o   = pause;
   assign marker_v_o   = marker;
   assign ready_o      = running && !pause && !marker;
   assign scram_v_o    = !pause && !marker;
   assign idle_force_o = !running;
   assign gb_seq_o     = gb_seq;
   assign am_cnt_o     = am_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state  <= IDLE;
         gb_seq <= '0;
         am_cnt <= '0;
      end else begin
         gb_seq <= pause ? '0 : gb_seq + SEQ_W'(1);

         case (state)
            IDLE: begin
               am_cnt <= '0;
               if (en_i) begin
                  state  <= RUN;
                  // Preloading the last count makes the first block slot in RUN a marker.
                  am_cnt <= IS10 ? '0 : AM_LAST;
               end
            end
            RUN: begin
               if (!en_i) begin
                  state  <= IDLE;
                  am_cnt <= '0;
               end else if (!IS10 && !pause) begin
                  am_cnt <= marker ? '0 : am_cnt + AM_W'(1);
               end
            end
            default: begin
               state  <= IDLE;
               am_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pcs_tx_sched.sv
// Self-checking bench for pcs_tx_sched: reference model feeding a scoreboard queue,
// a vector table for the marker sequence, and directed multi-cycle corner cases.
module tb_pcs_tx_sched;

   localparam int AMP      = 8;
   localparam int SEQ_MAX  = 32;
   localparam int SEQ_W    = 6;
   localparam int AM_W     = 3;

   typedef struct {
      logic             ready;
      logic             marker;
      logic             scram;
      logic             pause;
      logic             idle;
      logic [SEQ_W-1:0] seq;
      logic [AM_W-1:0]  am;
   } exp_t;

   typedef struct {
      logic             en;
      logic             ready;
      logic             marker;
      logic [SEQ_W-1:0] seq;
      logic [AM_W-1:0]  am;
   } vec_t;

   logic             clk = 1'b0;
   logic             nreset;
   logic             en;
   logic             en10;

   logic             ready, marker_v, scram_v, gb_pause, idle_force;
   logic [SEQ_W-1:0] gb_seq;
   logic [AM_W-1:0]  am_cnt;

   logic             ready10, marker_v10, scram_v10, gb_pause10, idle_force10;
   logic [SEQ_W-1:0] gb_seq10;
   logic [AM_W-1:0]  am_cnt10;

   int checks = 0;
   int errors = 0;

   // Reference model state: register values the DUT should hold after the latest edge.
   bit m_run = 1'b0;
   int m_seq = 0;
   int m_am  = 0;

   exp_t sb_q[$];
   vec_t vt[10];

   always #5 clk = ~clk;

   pcs_tx_sched #(
      .IS_10G(0), .DATA_W(64), .HEAD_W(2), .AM_PERIOD(AMP)
   ) dut (
      .clk(clk), .nreset(nreset), .en_i(en),
      .ready_o(ready), .marker_v_o(marker_v), .scram_v_o(scram_v),
      .gb_pause_o(gb_pause), .gb_seq_o(gb_seq), .idle_force_o(idle_force),
      .am_cnt_o(am_cnt)
   );

   pcs_tx_sched #(
      .IS_10G(1), .DATA_W(64), .HEAD_W(2), .AM_PERIOD(AMP)
   ) dut10 (
      .clk(clk), .nreset(nreset), .en_i(en10),
      .ready_o(ready10), .marker_v_o(marker_v10), .scram_v_o(scram_v10),
      .gb_pause_o(gb_pause10), .gb_seq_o(gb_seq10), .idle_force_o(idle_force10),
      .am_cnt_o(am_cnt10)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_update(input logic r, input logic e);
      bit slot;
      bit mk;
      slot = (m_seq != SEQ_MAX);
      mk   = m_run && (m_am == AMP-1) && slot;
      if (!r) begin
         m_run = 1'b0;
         m_seq = 0;
         m_am  = 0;
      end else begin
         m_seq = (m_seq == SEQ_MAX) ? 0 : m_seq + 1;
         if (!m_run) begin
            if (e) begin
               m_run = 1'b1;
               m_am  = AMP-1;
            end
         end else if (!e) begin
            m_run = 1'b0;
            m_am  = 0;
         end else if (slot) begin
            m_am = mk ? 0 : m_am + 1;
         end
      end
   endfunction

   function automatic exp_t model_out();
      exp_t x;
      x.pause  = (m_seq == SEQ_MAX);
      x.marker = m_run && (m_am == AMP-1) && !x.pause;
      x.ready  = m_run && !x.pause && !x.marker;
      x.scram  = !x.pause && !x.marker;
      x.idle   = !m_run;
      x.seq    = SEQ_W'(m_seq);
      x.am     = AM_W'(m_am);
      return x;
   endfunction

   task automatic check_sb();
      exp_t x;
      if (sb_q.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
         return;
      end
      x = sb_q.pop_front();
      check("sb_ready",  32'(ready),      32'(x.ready));
      check("sb_marker", 32'(marker_v),   32'(x.marker));
      check("sb_scram",  32'(scram_v),    32'(x.scram));
      check("sb_pause",  32'(gb_pause),   32'(x.pause));
      check("sb_idle",   32'(idle_force), 32'(x.idle));
      check("sb_seq",    32'(gb_seq),     32'(x.seq));
      check("sb_am",     32'(am_cnt),     32'(x.am));
   endtask

   // Called at a falling edge: drive inputs, queue the post-edge expectation, then
   // compare at the next falling edge.
   task automatic cyc(input logic r, input logic e);
      nreset = r;
      en     = e;
      model_update(r, e);
      sb_q.push_back(model_out());
      @(negedge clk);
      check_sb();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int n_ready;
      int n_marker;
      int diff;

      vt[0] = '{1'b1, 1'b0, 1'b1, 6'd6,  3'd7};
      vt[1] = '{1'b1, 1'b1, 1'b0, 6'd7,  3'd0};
      vt[2] = '{1'b1, 1'b1, 1'b0, 6'd8,  3'd1};
      vt[3] = '{1'b1, 1'b1, 1'b0, 6'd9,  3'd2};
      vt[4] = '{1'b1, 1'b1, 1'b0, 6'd10, 3'd3};
      vt[5] = '{1'b1, 1'b1, 1'b0, 6'd11, 3'd4};
      vt[6] = '{1'b1, 1'b1, 1'b0, 6'd12, 3'd5};
      vt[7] = '{1'b1, 1'b1, 1'b0, 6'd13, 3'd6};
      vt[8] = '{1'b1, 1'b0, 1'b1, 6'd14, 3'd7};
      vt[9] = '{1'b1, 1'b1, 1'b0, 6'd15, 3'd0};

      nreset = 1'b0;
      en     = 1'b0;
      en10   = 1'b0;
      @(negedge clk);

      // 1: reset, then idle with the gearbox free-running
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
      check("t1_reset_scram", 32'(scram_v), 32'd1);
      check("t1_reset_idle",  32'(idle_force), 32'd1);
      for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0);

      // 2: raise en at gb_seq=5, marker first, then seven data slots, then marker
      n = 0;
      while (m_seq != 5 && n < 40) begin
         cyc(1'b1, 1'b0);
         n++;
      end
      check("t2_start_seq", 32'(gb_seq), 32'd5);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, vt[i].en);
         check($sformatf("t2_vec%0d_ready", i),  32'(ready),    32'(vt[i].ready));
         check($sformatf("t2_vec%0d_marker", i), 32'(marker_v), 32'(vt[i].marker));
         check($sformatf("t2_vec%0d_seq", i),    32'(gb_seq),   32'(vt[i].seq));
         check($sformatf("t2_vec%0d_am", i),     32'(am_cnt),   32'(vt[i].am));
      end

      // 3: marker due on the pause cycle is deferred to gb_seq=0
      cyc(1'b1, 1'b0);
      n = 0;
      while (m_seq != 23 && n < 40) begin
         cyc(1'b1, 1'b0);
         n++;
      end
      cyc(1'b1, 1'b1);
      n = 0;
      while (m_seq != SEQ_MAX && n < 40) begin
         cyc(1'b1, 1'b1);
         n++;
      end
      check("t3_pause_seq",    32'(gb_seq),   32'd32);
      check("t3_pause",        32'(gb_pause), 32'd1);
      check("t3_pause_marker", 32'(marker_v), 32'd0);
      check("t3_pause_ready",  32'(ready),    32'd0);
      check("t3_pause_am",     32'(am_cnt),   32'd7);
      cyc(1'b1, 1'b1);
      check("t3_defer_seq",    32'(gb_seq),   32'd0);
      check("t3_defer_marker", 32'(marker_v), 32'd1);
      check("t3_defer_ready",  32'(ready),    32'd0);
      check("t3_defer_scram",  32'(scram_v),  32'd0);
      cyc(1'b1, 1'b1);
      check("t3_after_am",     32'(am_cnt),   32'd0);
      check("t3_after_ready",  32'(ready),    32'd1);

      // 4: long run, data slots versus markers
      n_ready  = 0;
      n_marker = 0;
      for (int i = 0; i < 330; i++) begin
         cyc(1'b1, 1'b1);
         if (ready === 1'b1)    n_ready++;
         if (marker_v === 1'b1) n_marker++;
      end
      diff = n_ready - 7 * n_marker;
      check("t4_ratio",   32'(diff >= -7 && diff <= 7), 32'd1);
      check("t4_markers", 32'(n_marker >= 39),           32'd1);

      // 5: drop en at am_cnt=3, then a one-cycle reset pulse during RUN
      n = 0;
      while (m_am != 3 && n < 20) begin
         cyc(1'b1, 1'b1);
         n++;
      end
      check("t5_drop_am", 32'(am_cnt), 32'd3);
      cyc(1'b1, 1'b0);
      check("t5_idle",       32'(idle_force), 32'd1);
      check("t5_idle_am",    32'(am_cnt),     32'd0);
      check("t5_idle_ready", 32'(ready),      32'd0);
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
      check("t5_run_again", 32'(idle_force), 32'd0);
      cyc(1'b0, 1'b1);
      check("t5_rst_ready",  32'(ready),      32'd0);
      check("t5_rst_marker", 32'(marker_v),   32'd0);
      check("t5_rst_pause",  32'(gb_pause),   32'd0);
      check("t5_rst_scram",  32'(scram_v),    32'd1);
      check("t5_rst_idle",   32'(idle_force), 32'd1);
      check("t5_rst_seq",    32'(gb_seq),     32'd0);
      check("t5_rst_am",     32'(am_cnt),     32'd0);
      cyc(1'b1, 1'b0);

      // 6: 10G instance never marks; every non-pause slot is ready
      en10 = 1'b1;
      cyc(1'b1, 1'b0);
      check("t6_run", 32'(idle_force10), 32'd0);
      for (int i = 0; i < 100; i++) begin
         cyc(1'b1, 1'b0);
         check("t6_marker", 32'(marker_v10), 32'd0);
         check("t6_ready",  32'(ready10),    32'(m_seq != SEQ_MAX));
         check("t6_pause",  32'(gb_pause10), 32'(m_seq == SEQ_MAX));
         check("t6_am",     32'(am_cnt10),   32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
